// File: rtl/rgmii_frame_tx.sv
// rtl/rgmii_frame_tx.sv - streaming Ethernet frame transmitter for RGMII TX oddr lanes (FCS via TX_FCS_EN)
module rgmii_frame_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12,
  parameter int MIN_BYTES      = 60,
  parameter int MAX_BYTES      = 1514,
  localparam int CW            = $clog2(MAX_BYTES + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  input  logic          i_last,
  output logic          o_ready,
  output logic [7:0]    o_txd,
  output logic          o_txen,
  output logic          o_txer,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [CW-1:0] o_len
);

  localparam logic [7:0]    PRE_LOAD = 8'(PREAMBLE_BYTES);
  // IDLE supplies the final gap byte, so IFG itself runs one cycle short
  localparam logic [7:0]    IFG_LOAD = 8'(IFG_BYTES - 1);
  localparam bit            IFG_SKIP = (IFG_BYTES == 1);
  localparam logic [CW-1:0] MIN_L    = CW'(MIN_BYTES);
  localparam logic [CW-1:0] MAX_L    = CW'(MAX_BYTES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_ERR,
    S_DROP,
    S_IFG
`ifdef TX_FCS_EN
    , S_FCS
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   len_inc;
  logic [7:0]      txd_q, txd_d;
  logic            txen_q, txen_d;
  logic            txer_q, txer_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready;
  logic            payload_end;
  logic            to_ifg;

`ifdef TX_FCS_EN
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     fcs;

  // reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte LSB first
  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ din[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs = ~crc_q;
`endif

  assign len_inc = len_q + CW'(1);

  // next-state, next-byte and pulse decode; the state names the byte loaded at the next edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    txd_d       = 8'h00;
    txen_d      = 1'b0;
    txer_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ready       = 1'b0;
    payload_end = 1'b0;
    to_ifg      = 1'b0;
`ifdef TX_FCS_EN
    crc_d       = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_PRE;
          cnt_d   = PRE_LOAD;
        end
      end
      S_PRE: begin
        txd_d  = 8'h55;
        txen_d = 1'b1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_SFD;
        end
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        txen_d  = 1'b1;
        len_d   = '0;
        state_d = S_DATA;
`ifdef TX_FCS_EN
        crc_d   = 32'hFFFFFFFF;
`endif
      end
      S_DATA: begin
        ready = 1'b1;
        if (i_valid) begin
          txd_d  = i_data;
          txen_d = 1'b1;
          len_d  = len_inc;
`ifdef TX_FCS_EN
          crc_d  = crc_next(crc_q, i_data);
`endif
          if (i_last) begin
            if (len_inc < MIN_L) begin
              state_d = S_PAD;
            end else begin
              payload_end = 1'b1;
            end
          end else if (len_inc == MAX_L) begin
            state_d = S_ERR;
          end
        end else begin
          // underrun: the error byte goes out on this edge so TX_EN never gaps
          txen_d = 1'b1;
          txer_d = 1'b1;
          err_d  = 1'b1;
          to_ifg = 1'b1;
        end
      end
      S_PAD: begin
        txen_d = 1'b1;
        len_d  = len_inc;
`ifdef TX_FCS_EN
        crc_d  = crc_next(crc_q, 8'h00);
`endif
        if (len_inc == MIN_L) begin
          payload_end = 1'b1;
        end
      end
`ifdef TX_FCS_EN
      S_FCS: begin
        txd_d  = fcs[{cnt_q[1:0], 3'b000} +: 8];
        txen_d = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q[1:0] == 2'd3) begin
          done_d = 1'b1;
          to_ifg = 1'b1;
        end
      end
`endif
      S_ERR: begin
        txen_d  = 1'b1;
        txer_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_DROP;
      end
      S_DROP: begin
        ready = 1'b1;
        if (i_valid && i_last) begin
          to_ifg = 1'b1;
        end
      end
      S_IFG: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (payload_end) begin
`ifdef TX_FCS_EN
      state_d = S_FCS;
      cnt_d   = 8'd0;
`else
      done_d  = 1'b1;
      to_ifg  = 1'b1;
`endif
    end

    if (to_ifg) begin
      state_d = IFG_SKIP ? S_IDLE : S_IFG;
      cnt_d   = IFG_LOAD;
    end
  end

  // state and registered outputs; reset drops TX_EN immediately mid-frame
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      len_q   <= '0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TX_FCS_EN
      crc_q   <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef TX_FCS_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign o_ready = ready;
  assign o_txd   = txd_q;
  assign o_txen  = txen_q;
  assign o_txer  = txer_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_len   = len_q;

endmodule

// File: tb/tb_rgmii_frame_tx.sv
// tb/tb_rgmii_frame_tx.sv - table-driven self-checking bench for rgmii_frame_tx
module tb_rgmii_frame_tx;

  localparam int PRE = 7;
  localparam int IFG = 12;
  localparam int MIN = 60;
  localparam int MAX = 64;
  localparam int CW  = $clog2(MAX + 1);
`ifdef TX_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif

  typedef struct {
    int n;      // bytes offered by the source
    int stop;   // drop i_valid after this many handshakes (0 = never)
    int len;    // expected o_len after the frame
    int txen;   // expected o_txen-high cycles (without FCS)
    int done;   // expected o_done pulses
    int err;    // expected o_err pulses
    int idle;   // expected cycles from end of driving until o_busy low (without FCS)
  } vec_t;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          i_last;
  logic          o_ready;
  logic [7:0]    o_txd;
  logic          o_txen;
  logic          o_txer;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [CW-1:0] o_len;

  int applied = 0;
  int miscompares = 0;

  logic [8:0] cap[$];
  int txen_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int idle_run = 0;
  int last_gap = 0;
  bit prev_txen = 1'b0;

  int b_cap, b_txen, b_done, b_err;
  vec_t tbl[10];
  int idle, lat;

  rgmii_frame_tx #(
    .PREAMBLE_BYTES(PRE),
    .IFG_BYTES(IFG),
    .MIN_BYTES(MIN),
    .MAX_BYTES(MAX)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_last(i_last),
    .o_ready(o_ready),
    .o_txd(o_txd),
    .o_txen(o_txen),
    .o_txer(o_txer),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_len(o_len)
  );

  always #4 i_clk = ~i_clk;

  // line monitor: captures every TX_EN byte and counts pulses and gaps
  always @(negedge i_clk) begin
    if (o_txen) begin
      cap.push_back({o_txer, o_txd});
      txen_cnt++;
      if (!prev_txen) last_gap = idle_run;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_txen = o_txen;
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
  end

  function automatic logic [7:0] pat(input int v, input int i);
    return 8'(i * 7 + v * 13 + 1);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mark();
    b_cap  = cap.size();
    b_txen = txen_cnt;
    b_done = done_cnt;
    b_err  = err_cnt;
  endtask

  task automatic drive_frame(input int v, input int n, input int stop, input bit hold);
    int idx;
    int guard;
    bit hs;
    idx = 0;
    guard = 0;
    i_valid = 1'b1;
    i_data = pat(v, 0);
    i_last = (n == 1);
    while (idx < n && guard < 4000) begin
      hs = o_ready;
      @(negedge i_clk);
      guard++;
      if (hs) begin
        idx++;
        if (stop > 0 && idx == stop) begin
          i_valid = 1'b0;
          i_last = 1'b0;
          idx = n;
        end else if (idx < n) begin
          i_data = pat(v, idx);
          i_last = (idx == n - 1);
        end else begin
          i_valid = hold;
          i_last = 1'b0;
        end
      end
    end
    check("drive_complete", int'(guard < 4000), 1);
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (o_busy && c < 500) begin
      @(negedge i_clk);
      c++;
    end
    check("idle_reached", int'(c < 500), 1);
  endtask

  task automatic check_frame(input int v, input vec_t t, input int idl);
    logic [8:0] exp_q[$];
    logic [31:0] crc;
    logic [7:0] b;
    int nd, nbad, good;
    #1;
    exp_q.delete();
    for (int k = 0; k < PRE; k++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    good = int'((t.stop == 0) && (t.n <= MAX));
    nd = (t.stop > 0) ? t.stop : ((t.n > MAX) ? MAX : t.n);
    crc = 32'hFFFFFFFF;
    for (int k = 0; k < nd; k++) begin
      b = pat(v, k);
      exp_q.push_back({1'b0, b});
      crc = crc_upd(crc, b);
    end
    if (good == 0) begin
      exp_q.push_back(9'h100);
    end else begin
      for (int k = nd; k < MIN; k++) begin
        exp_q.push_back(9'h000);
        crc = crc_upd(crc, 8'h00);
      end
`ifdef TX_FCS_EN
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, crc[8*k +: 8]});
`endif
    end
    check("txen_cycles", txen_cnt - b_txen, t.txen + good * FCS_N);
    check("len", int'(o_len), t.len);
    check("done_pulses", done_cnt - b_done, t.done);
    check("err_pulses", err_cnt - b_err, t.err);
    check("ifg_idle", idl, t.idle + good * FCS_N);
    nbad = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (b_cap + k >= cap.size()) nbad++;
      else if (cap[b_cap + k] !== exp_q[k]) nbad++;
    end
    check("frame_bytes_bad", nbad, 0);
  endtask

  initial begin
    i_rstn = 1'b1;
    i_valid = 1'b0;
    i_data = 8'h00;
    i_last = 1'b0;

    tbl[0] = '{1,  0,  60, 68, 1, 0, 70};
    tbl[1] = '{10, 0,  60, 68, 1, 0, 61};
    tbl[2] = '{59, 0,  60, 68, 1, 0, 12};
    tbl[3] = '{60, 0,  60, 68, 1, 0, 11};
    tbl[4] = '{61, 0,  61, 69, 1, 0, 11};
    tbl[5] = '{64, 0,  64, 72, 1, 0, 11};
    tbl[6] = '{40, 20, 20, 29, 0, 1, 12};
    tbl[7] = '{5,  1,  1,  10, 0, 1, 12};
    tbl[8] = '{70, 0,  64, 73, 0, 1, 11};
    tbl[9] = '{65, 0,  64, 73, 0, 1, 11};

    #1 i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_txd", int'(o_txd), 0);
    check("rst_txen", int'(o_txen), 0);
    check("rst_txer", int'(o_txer), 0);
    check("rst_ready", int'(o_ready), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_len", int'(o_len), 0);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int i = 0; i < 10; i++) begin
      mark();
      if (i == 0) begin
        i_valid = 1'b1;
        i_data = pat(0, 0);
        i_last = 1'b1;
        lat = 0;
        while (!o_ready && lat < 40) begin
          @(negedge i_clk);
          lat++;
        end
        check("ready_latency", lat, PRE + 2);
      end
      drive_frame(i, tbl[i].n, tbl[i].stop, 1'b0);
      wait_idle(idle);
      check_frame(i, tbl[i], idle);
      @(negedge i_clk);
    end

    // back-to-back frames with i_valid held high across the gap
    mark();
    drive_frame(20, 64, 0, 1'b1);
    drive_frame(21, 64, 0, 1'b0);
    wait_idle(idle);
    #1;
    check("b2b_gap", last_gap, IFG);
    check("b2b_txen", txen_cnt - b_txen, 2 * (72 + FCS_N));
    check("b2b_done", done_cnt - b_done, 2);
    check("b2b_idle", idle, 11 + FCS_N);
    @(negedge i_clk);

    // reset in the middle of DATA
    i_valid = 1'b1;
    i_data = 8'hA5;
    i_last = 1'b0;
    repeat (15) @(negedge i_clk);
    check("mid_txen", int'(o_txen), 1);
    check("mid_len", int'(o_len), 6);
    #1 i_rstn = 1'b0;
    #1;
    check("mrst_txen", int'(o_txen), 0);
    check("mrst_ready", int'(o_ready), 0);
    check("mrst_busy", int'(o_busy), 0);
    check("mrst_len", int'(o_len), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("rel_busy", int'(o_busy), 1);
    check("rel_txen", int'(o_txen), 0);
    @(negedge i_clk);
    check("rel_pre_txen", int'(o_txen), 1);
    check("rel_pre_txd", int'(o_txd), 8'h55);
    i_valid = 1'b0;
    wait_idle(idle);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
